// File: rtl/tpu_mac_pkg.sv
// Shared constants and element helpers for the matrix-MAC front end.
// A 64-bit word is a 2x2 matrix of 16-bit unsigned elements, row-major from bit 0.
package tpu_mac_pkg;

  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 8;
  localparam int ELEM_W     = 16;
  localparam int WORD_W     = 64;
  localparam int CNT_W      = $clog2(WORD_BYTES);

  // Element (r,c) lives at bits [16*(2r+c)+15 : 16*(2r+c)].
  function automatic logic [ELEM_W-1:0] get_elem(input logic [WORD_W-1:0] word,
                                                 input int unsigned r,
                                                 input int unsigned c);
    return word[ELEM_W*(2*r+c) +: ELEM_W];
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Collects eight input bytes little-endian into one word and publishes it as matrix_b,
// with a one-cycle word_done pulse following the edge that completes the word.
module byte_word_assembler
  import tpu_mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] datos_in,
  input  logic              wr_strobe,
  output logic [WORD_W-1:0] matrix_b,
  output logic              word_done
);

  logic [CNT_W-1:0]  byte_cnt;
  logic [WORD_W-1:0] asm_word;
  logic [WORD_W-1:0] asm_next;

  // Word as it will look once the current byte lands; feeds matrix_b on the last byte.
  always_comb begin
    asm_next = asm_word;
    asm_next[BYTE_W*byte_cnt +: BYTE_W] = datos_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_cnt  <= '0;
      asm_word  <= '0;
      matrix_b  <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (wr_strobe) begin
        asm_word <= asm_next;
        byte_cnt <= byte_cnt + 1'b1;
        if (byte_cnt == CNT_W'(WORD_BYTES - 1)) begin
          matrix_b  <= asm_next;
          word_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tpu_mac_core.sv
// Matrix-MAC front end: byte stream -> alternating A/B 2x2 operands -> A x B,
// accumulated element-wise into acc_out. All element arithmetic is mod 2^16.
module tpu_mac_core
  import tpu_mac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] datos_in,
  input  logic              ena_write,
  input  logic              enable_accu,
  input  logic              clear,
  output logic [WORD_W-1:0] matrix_a,
  output logic [WORD_W-1:0] matrix_b,
  output logic [WORD_W-1:0] product,
  output logic [WORD_W-1:0] acc_out,
  output logic              word_done,
  output logic              a_loaded
);

  // Low 16 bits of a sum of products depend only on the low 16 bits of each term,
  // so evaluating in the 16-bit element width equals full-width then truncate.
  function automatic logic [ELEM_W-1:0] mac_elem(input logic [ELEM_W-1:0] a0,
                                                 input logic [ELEM_W-1:0] b0,
                                                 input logic [ELEM_W-1:0] a1,
                                                 input logic [ELEM_W-1:0] b1);
    return a0 * b0 + a1 * b1;
  endfunction

  function automatic logic [ELEM_W-1:0] wrap_add(input logic [ELEM_W-1:0] x,
                                                 input logic [ELEM_W-1:0] y);
    return x + y;
  endfunction

  logic wr_d;
  logic acc_d;
  logic wr_strobe;
  logic acc_strobe;

  assign wr_strobe  = ena_write & ~wr_d;
  assign acc_strobe = enable_accu & ~acc_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_d  <= 1'b0;
      acc_d <= 1'b0;
    end else begin
      wr_d  <= ena_write;
      acc_d <= enable_accu;
    end
  end

  byte_word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .datos_in  (datos_in),
    .wr_strobe (wr_strobe),
    .matrix_b  (matrix_b),
    .word_done (word_done)
  );

  // Odd-numbered words become A; the following even-numbered word stays in matrix_b as B.
  always_ff @(posedge clk) begin
    if (!rst) begin
      matrix_a <= '0;
      a_loaded <= 1'b0;
    end else if (word_done) begin
      if (!a_loaded) begin
        matrix_a <= matrix_b;
        a_loaded <= 1'b1;
      end else begin
        a_loaded <= 1'b0;
      end
    end
  end

  always_comb begin
    product = '0;
    for (int unsigned r = 0; r < 2; r++) begin
      for (int unsigned c = 0; c < 2; c++) begin
        product[ELEM_W*(2*r+c) +: ELEM_W] = mac_elem(get_elem(matrix_a, r, 0),
                                                     get_elem(matrix_b, 0, c),
                                                     get_elem(matrix_a, r, 1),
                                                     get_elem(matrix_b, 1, c));
      end
    end
  end

  // Clear wins over a coincident accumulate; no carry crosses element boundaries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_out <= '0;
    end else if (clear) begin
      acc_out <= '0;
    end else if (acc_strobe) begin
      for (int unsigned e = 0; e < 4; e++) begin
        acc_out[ELEM_W*e +: ELEM_W] <= wrap_add(acc_out[ELEM_W*e +: ELEM_W],
                                                product[ELEM_W*e +: ELEM_W]);
      end
    end
  end

endmodule

// File: tb/tb_tpu_mac_core.sv
// Bench for tpu_mac_core: directed sequences, a vector table and randomized words/accumulates.
module tb_tpu_mac_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  datos_in = '0;
  logic        ena_write = 1'b0;
  logic        enable_accu = 1'b0;
  logic        clear = 1'b0;
  logic [63:0] matrix_a, matrix_b, product, acc_out;
  logic        word_done, a_loaded;

  int n_chk = 0;
  int n_pass = 0;

  tpu_mac_core dut (
    .clk         (clk),
    .rst         (rst),
    .datos_in    (datos_in),
    .ena_write   (ena_write),
    .enable_accu (enable_accu),
    .clear       (clear),
    .matrix_a    (matrix_a),
    .matrix_b    (matrix_b),
    .product     (product),
    .acc_out     (acc_out),
    .word_done   (word_done),
    .a_loaded    (a_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
  endtask

  function automatic logic [63:0] model_mul(input logic [63:0] a, input logic [63:0] b);
    longint ea[2][2];
    longint eb[2][2];
    logic [63:0] res;
    longint s;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        ea[i][j] = longint'(a[16*(2*i+j) +: 16]);
        eb[i][j] = longint'(b[16*(2*i+j) +: 16]);
      end
    res = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s += ea[i][k] * eb[k][j];
        res[16*(2*i+j) +: 16] = 16'(s % 65536);
      end
    return res;
  endfunction

  function automatic logic [63:0] model_acc(input logic [63:0] acc, input logic [63:0] p);
    logic [63:0] res;
    longint s;
    for (int e = 0; e < 4; e++) begin
      s = longint'(acc[16*e +: 16]) + longint'(p[16*e +: 16]);
      res[16*e +: 16] = 16'(s % 65536);
    end
    return res;
  endfunction

  task automatic do_reset();
    ena_write = 1'b0; enable_accu = 1'b0; clear = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic wd_hi, output logic wd_lo);
    datos_in = b;
    ena_write = 1'b1;
    @(posedge clk); #1;
    wd_hi = word_done;
    ena_write = 1'b0;
    @(posedge clk); #1;
    wd_lo = word_done;
  endtask

  task automatic write_word(input logic [63:0] w, input bit chk_done);
    logic hi, lo;
    for (int k = 0; k < 8; k++) begin
      write_byte(w[8*k +: 8], hi, lo);
      if (chk_done && k >= 6) chk($sformatf("word_done_byte%0d", k), 64'(hi), 64'(k == 7));
      if (chk_done && k == 7) chk("word_done_pulse_end", 64'(lo), 64'd0);
    end
  endtask

  task automatic acc_pulse();
    enable_accu = 1'b1;
    @(posedge clk); #1;
    enable_accu = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  initial begin
    logic hi, lo;
    logic [63:0] w, ma, mb, macc;
    int nwords;

    vecs[0] = '{a: 64'h0001_0000_0000_0001, b: 64'h0005_0004_0003_0002, p: 64'h0005_0004_0003_0002};
    vecs[1] = '{a: 64'h0100_0000_0000_0100, b: 64'h0100_0000_0000_0100, p: 64'h0000_0000_0000_0000};
    vecs[2] = '{a: 64'h0000_0000_0000_FFFF, b: 64'h0000_0000_0000_0002, p: 64'h0000_0000_0000_FFFE};
    vecs[3] = '{a: 64'h0004_0003_0002_0001, b: 64'h0008_0007_0006_0005, p: 64'h0032_002B_0016_0013};

    // Reset state
    @(posedge clk); #1;
    do_reset();
    chk("rst_matrix_a", matrix_a, 64'd0);
    chk("rst_matrix_b", matrix_b, 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_acc_out", acc_out, 64'd0);
    chk("rst_word_done", 64'(word_done), 64'd0);
    chk("rst_a_loaded", 64'(a_loaded), 64'd0);

    // Identity x B with word_done pulses, then two accumulations
    write_word(64'h0001_0000_0000_0001, 1'b1);
    chk("id_a_loaded_after_A", 64'(a_loaded), 64'd1);
    write_word(64'h0005_0004_0003_0002, 1'b1);
    chk("id_matrix_a", matrix_a, 64'h0001_0000_0000_0001);
    chk("id_product", product, 64'h0005_0004_0003_0002);
    chk("id_a_loaded_after_B", 64'(a_loaded), 64'd0);
    acc_pulse();
    chk("acc_first", acc_out, 64'h0005_0004_0003_0002);
    acc_pulse();
    chk("acc_second", acc_out, 64'h000A_0008_0006_0004);

    // Clear coincident with an accumulate edge: clear wins
    enable_accu = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    chk("clear_priority", acc_out, 64'd0);
    enable_accu = 1'b0; clear = 1'b0;
    @(posedge clk); #1;
    chk("clear_hold_zero", acc_out, 64'd0);

    // Held enable_accu for 5 cycles gives exactly one accumulation
    enable_accu = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    enable_accu = 1'b0;
    @(posedge clk); #1;
    chk("acc_held_once", acc_out, 64'h0005_0004_0003_0002);

    // Held ena_write captures only the first byte
    ena_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      datos_in = 8'hA0 + 8'(i);
      @(posedge clk); #1;
    end
    ena_write = 1'b0;
    @(posedge clk); #1;
    for (int k = 1; k < 7; k++) write_byte(8'hB0 + 8'(k), hi, lo);
    chk("held_7bytes_no_word", matrix_b, 64'h0005_0004_0003_0002);
    write_byte(8'hB7, hi, lo);
    chk("held_8th_word_done", 64'(hi), 64'd1);
    chk("held_matrix_b", matrix_b, 64'hB7B6_B5B4_B3B2_B1A0);
    chk("held_matrix_a", matrix_a, 64'hB7B6_B5B4_B3B2_B1A0);
    chk("held_a_loaded", 64'(a_loaded), 64'd1);

    // Reset mid-word discards the partial word
    for (int k = 0; k < 3; k++) write_byte(8'hEE, hi, lo);
    do_reset();
    chk("midrst_acc_zero", acc_out, 64'd0);
    chk("midrst_a_loaded_zero", 64'(a_loaded), 64'd0);
    write_word(64'h8877_6655_4433_2211, 1'b0);
    chk("midrst_matrix_a", matrix_a, 64'h8877_6655_4433_2211);
    chk("midrst_a_loaded", 64'(a_loaded), 64'd1);
    chk("midrst_acc_out", acc_out, 64'd0);

    // Vector table: each entry loads A then B from a clean state
    for (int v = 0; v < 4; v++) begin
      do_reset();
      write_word(vecs[v].a, 1'b0);
      write_word(vecs[v].b, 1'b0);
      chk($sformatf("tbl%0d_matrix_a", v), matrix_a, vecs[v].a);
      chk($sformatf("tbl%0d_matrix_b", v), matrix_b, vecs[v].b);
      chk($sformatf("tbl%0d_product", v), product, vecs[v].p);
      acc_pulse();
      chk($sformatf("tbl%0d_acc", v), acc_out, vecs[v].p);
    end

    // Randomized words and accumulator operations against the reference model
    do_reset();
    nwords = 0; ma = '0; mb = '0; macc = '0;
    for (int it = 0; it < 24; it++) begin
      w = {$urandom, $urandom};
      write_word(w, 1'b0);
      nwords++;
      if (nwords % 2 == 1) ma = w;
      mb = w;
      chk($sformatf("rnd%0d_matrix_a", it), matrix_a, ma);
      chk($sformatf("rnd%0d_matrix_b", it), matrix_b, mb);
      chk($sformatf("rnd%0d_a_loaded", it), 64'(a_loaded), 64'(nwords % 2));
      chk($sformatf("rnd%0d_product", it), product, model_mul(ma, mb));
      case ($urandom_range(0, 3))
        0, 1: begin acc_pulse(); macc = model_acc(macc, model_mul(ma, mb)); end
        2: begin clear_pulse(); macc = '0; end
        default: ;
      endcase
      chk($sformatf("rnd%0d_acc", it), acc_out, macc);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
